// File: rtl/neuron_train_ctrl.sv
// ----------------------------------------------------------------------------
// neuron_train_ctrl
//
// Trains the neuron core over a small on-chip sample set and then serves
// single host inference requests through it.
// Training epochs run in LEARNING mode until an epoch has no mispredictions
// or the epoch limit is reached.
//
// Optional feature: define NEURON_TRAIN_CTRL_TIMEOUT_EN to add a watchdog on
// the result wait. Without it the block waits for results indefinitely and
// o_timeout is tied low.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start                   one-cycle pulse that begins training
//   i_smp_wr_*                training-sample write port (IDLE only)
//   o_busy / o_done           activity flag / end-of-training pulse
//   o_converged, o_timeout    outcome of the last training run
//   o_epoch_cnt, o_err_cnt    epochs completed / errors in last epoch
//   i_inf_vld/o_inf_rdy/i_inf_data   host inference request
//   o_inf_res_vld/o_inf_res_data     inference result pulse and bit
//   o_nrn_*, i_nrn_*          neuron data port (valid/ready) and result
// ----------------------------------------------------------------------------
module neuron_train_ctrl #(
    parameter int unsigned INPUTS_NUM     = 3,
    parameter int unsigned NUM_SAMPLES    = 8,
    parameter int unsigned MAX_EPOCHS     = 255,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_start,
    input  logic                               i_smp_wr_en,
    input  logic [$clog2(NUM_SAMPLES)-1:0]     i_smp_wr_addr,
    input  logic [INPUTS_NUM-1:0]              i_smp_wr_data,
    input  logic                               i_smp_wr_exp,
    output logic                               o_busy,
    output logic                               o_done,
    output logic                               o_converged,
    output logic                               o_timeout,
    output logic [$clog2(MAX_EPOCHS+1)-1:0]    o_epoch_cnt,
    output logic [$clog2(NUM_SAMPLES+1)-1:0]   o_err_cnt,
    input  logic                               i_inf_vld,
    output logic                               o_inf_rdy,
    input  logic [INPUTS_NUM-1:0]              i_inf_data,
    output logic                               o_inf_res_vld,
    output logic                               o_inf_res_data,
    output logic                               o_nrn_mode,
    output logic                               o_nrn_in_vld,
    input  logic                               i_nrn_in_rdy,
    output logic [INPUTS_NUM-1:0]              o_nrn_in_data,
    output logic                               o_nrn_expected,
    input  logic                               i_nrn_result_vld,
    input  logic                               i_nrn_result_data
);

    localparam int unsigned AW = $clog2(NUM_SAMPLES);
    localparam int unsigned EW = $clog2(MAX_EPOCHS + 1);
    localparam int unsigned CW = $clog2(NUM_SAMPLES + 1);

    typedef enum logic [2:0] {
        StIdle, StIssue, StWaitRes, StEpochEnd, StInfIssue, StInfWait
    } state_t;

    state_t                 r_state;
    logic [INPUTS_NUM-1:0]  r_mem_data [NUM_SAMPLES];
    logic [NUM_SAMPLES-1:0] r_mem_exp;
    logic [AW-1:0]          r_idx;
    logic [CW-1:0]          r_acc;
    logic [EW-1:0]          r_epoch_cnt;
    logic [CW-1:0]          r_err_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_converged;
    logic                   r_inf_en;
    logic                   r_inf_res_vld;
    logic                   r_inf_res_data;
    logic                   r_nrn_mode;
    logic                   r_nrn_in_vld;
    logic [INPUTS_NUM-1:0]  r_nrn_in_data;
    logic                   r_nrn_expected;

    logic [AW-1:0]          w_idx_nxt;
    logic                   w_last;
    logic                   w_mispredict;
    logic                   w_wr_ok;
    logic                   w_epoch_limit;

`ifdef NEURON_TRAIN_CTRL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]          r_to_cnt;
    logic                   r_timeout;
    logic                   w_to_hit;
    assign w_to_hit  = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign o_timeout = r_timeout;
`else
    logic                   w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign o_timeout    = 1'b0;
`endif

    assign w_idx_nxt     = r_idx + AW'(1);
    assign w_last        = (r_idx == AW'(NUM_SAMPLES - 1));
    assign w_mispredict  = (i_nrn_result_data != r_nrn_expected);
    assign w_wr_ok       = (r_state == StIdle) && i_smp_wr_en &&
                           (32'(i_smp_wr_addr) < NUM_SAMPLES);
    // Old count plus the epoch finishing now reaches the limit.
    assign w_epoch_limit = ((32'(r_epoch_cnt) + 32'd1) == MAX_EPOCHS);

    // Ready depends on the live start input so start wins over a request.
    // r_inf_en keeps ready low while reset is asserted.
    assign o_inf_rdy      = r_inf_en && (r_state == StIdle) && !i_start;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_converged    = r_converged;
    assign o_epoch_cnt    = r_epoch_cnt;
    assign o_err_cnt      = r_err_cnt;
    assign o_inf_res_vld  = r_inf_res_vld;
    assign o_inf_res_data = r_inf_res_data;
    assign o_nrn_mode     = r_nrn_mode;
    assign o_nrn_in_vld   = r_nrn_in_vld;
    assign o_nrn_in_data  = r_nrn_in_data;
    assign o_nrn_expected = r_nrn_expected;

    // Sample memory
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(NUM_SAMPLES); i++) begin
                r_mem_data[i] <= '0;
            end
            r_mem_exp <= '0;
        end else if (w_wr_ok) begin
            r_mem_data[i_smp_wr_addr] <= i_smp_wr_data;
            r_mem_exp[i_smp_wr_addr]  <= i_smp_wr_exp;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= StIdle;
            r_idx          <= '0;
            r_acc          <= '0;
            r_epoch_cnt    <= '0;
            r_err_cnt      <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_converged    <= 1'b0;
            r_inf_en       <= 1'b0;
            r_inf_res_vld  <= 1'b0;
            r_inf_res_data <= 1'b0;
            r_nrn_mode     <= 1'b0;
            r_nrn_in_vld   <= 1'b0;
            r_nrn_in_data  <= '0;
            r_nrn_expected <= 1'b0;
`ifdef NEURON_TRAIN_CTRL_TIMEOUT_EN
            r_to_cnt       <= '0;
            r_timeout      <= 1'b0;
`endif
        end else begin
            r_inf_en      <= 1'b1;
            r_done        <= 1'b0;
            r_inf_res_vld <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_epoch_cnt    <= '0;
                        r_err_cnt      <= '0;
                        r_converged    <= 1'b0;
                        r_idx          <= '0;
                        r_acc          <= '0;
                        r_busy         <= 1'b1;
                        r_nrn_mode     <= 1'b1;
                        r_nrn_in_vld   <= 1'b1;
                        r_nrn_in_data  <= r_mem_data[0];
                        r_nrn_expected <= r_mem_exp[0];
                        r_state        <= StIssue;
`ifdef NEURON_TRAIN_CTRL_TIMEOUT_EN
                        r_timeout      <= 1'b0;
`endif
                    end else if (i_inf_vld && r_inf_en) begin
                        r_busy         <= 1'b1;
                        r_nrn_mode     <= 1'b0;
                        r_nrn_in_vld   <= 1'b1;
                        r_nrn_in_data  <= i_inf_data;
                        r_nrn_expected <= 1'b0;
                        r_state        <= StInfIssue;
                    end
                end
                StIssue, StInfIssue: begin
                    if (i_nrn_in_rdy) begin
                        r_nrn_in_vld <= 1'b0;
                        r_state      <= (r_state == StIssue) ? StWaitRes : StInfWait;
`ifdef NEURON_TRAIN_CTRL_TIMEOUT_EN
                        r_to_cnt     <= '0;
`endif
                    end
                end
                StWaitRes: begin
                    if (i_nrn_result_vld) begin
                        if (w_mispredict) begin
                            r_acc <= r_acc + CW'(1);
                        end
                        if (w_last) begin
                            r_state <= StEpochEnd;
                        end else begin
                            r_idx          <= w_idx_nxt;
                            r_nrn_in_vld   <= 1'b1;
                            r_nrn_in_data  <= r_mem_data[w_idx_nxt];
                            r_nrn_expected <= r_mem_exp[w_idx_nxt];
                            r_state        <= StIssue;
                        end
                    end
`ifdef NEURON_TRAIN_CTRL_TIMEOUT_EN
                    else if (w_to_hit) begin
                        r_timeout   <= 1'b1;
                        r_converged <= 1'b0;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
`endif
                end
                StEpochEnd: begin
                    r_epoch_cnt <= r_epoch_cnt + EW'(1);
                    r_err_cnt   <= r_acc;
                    if (r_acc == '0 || w_epoch_limit) begin
                        r_converged <= (r_acc == '0);
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end else begin
                        r_idx          <= '0;
                        r_acc          <= '0;
                        r_nrn_in_vld   <= 1'b1;
                        r_nrn_in_data  <= r_mem_data[0];
                        r_nrn_expected <= r_mem_exp[0];
                        r_state        <= StIssue;
                    end
                end
                StInfWait: begin
                    if (i_nrn_result_vld) begin
                        r_inf_res_vld  <= 1'b1;
                        r_inf_res_data <= i_nrn_result_data;
                        r_busy         <= 1'b0;
                        r_state        <= StIdle;
                    end
`ifdef NEURON_TRAIN_CTRL_TIMEOUT_EN
                    else if (w_to_hit) begin
                        r_inf_res_vld  <= 1'b1;
                        r_inf_res_data <= 1'b0;
                        r_timeout      <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= StIdle;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
`endif
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_train_ctrl.sv
// Self-checking bench for neuron_train_ctrl: a behavioural neuron model,
// a training reference computed from a per-epoch misprediction table, and
// a scoreboard monitor that checks every done / inference result pulse.
module tb_neuron_train_ctrl;

    localparam int NI     = 3;
    localparam int NS     = 8;
    localparam int MAX_EP = 4;
    localparam int TMO    = 10;

    typedef struct {
        int ep;
        int err;
        bit conv;
        bit tmo;
    } train_exp_t;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       i_start = 1'b0;
    logic                       i_smp_wr_en = 1'b0;
    logic [2:0]                 i_smp_wr_addr = '0;
    logic [NI-1:0]              i_smp_wr_data = '0;
    logic                       i_smp_wr_exp = 1'b0;
    logic                       o_busy, o_done, o_converged, o_timeout;
    logic [$clog2(MAX_EP+1)-1:0] o_epoch_cnt;
    logic [$clog2(NS+1)-1:0]    o_err_cnt;
    logic                       i_inf_vld = 1'b0;
    logic                       o_inf_rdy;
    logic [NI-1:0]              i_inf_data = '0;
    logic                       o_inf_res_vld, o_inf_res_data;
    logic                       o_nrn_mode, o_nrn_in_vld;
    logic                       nrn_in_rdy = 1'b0;
    logic [NI-1:0]              o_nrn_in_data;
    logic                       o_nrn_expected;
    logic                       nrn_result_vld = 1'b0;
    logic                       nrn_result_data = 1'b0;

    train_exp_t q_train[$];
    bit         q_inf[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    bit [NI-1:0] tb_data[NS];
    bit         tb_exp[NS];
    bit         wrong_tab[MAX_EP+1][NS];
    bit         train_active = 0;
    bit         respond_en = 1;
    int         stall_cfg = -1;
    int         learn_k = 0;
    int         hs_cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;

    neuron_train_ctrl #(
        .INPUTS_NUM    (NI),
        .NUM_SAMPLES   (NS),
        .MAX_EPOCHS    (MAX_EP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (i_start),
        .i_smp_wr_en      (i_smp_wr_en),
        .i_smp_wr_addr    (i_smp_wr_addr),
        .i_smp_wr_data    (i_smp_wr_data),
        .i_smp_wr_exp     (i_smp_wr_exp),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_converged      (o_converged),
        .o_timeout        (o_timeout),
        .o_epoch_cnt      (o_epoch_cnt),
        .o_err_cnt        (o_err_cnt),
        .i_inf_vld        (i_inf_vld),
        .o_inf_rdy        (o_inf_rdy),
        .i_inf_data       (i_inf_data),
        .o_inf_res_vld    (o_inf_res_vld),
        .o_inf_res_data   (o_inf_res_data),
        .o_nrn_mode       (o_nrn_mode),
        .o_nrn_in_vld     (o_nrn_in_vld),
        .i_nrn_in_rdy     (nrn_in_rdy),
        .o_nrn_in_data    (o_nrn_in_data),
        .o_nrn_expected   (o_nrn_expected),
        .i_nrn_result_vld (nrn_result_vld),
        .i_nrn_result_data(nrn_result_data)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int count_wrong(input int e);
        int n;
        n = 0;
        if (e >= 1 && e <= MAX_EP) begin
            for (int s = 0; s < NS; s++) n += int'(wrong_tab[e][s]);
        end
        return n;
    endfunction

    // Training outcome straight from the rules: first clean epoch converges,
    // otherwise stop at the epoch limit.
    function automatic train_exp_t ref_train();
        train_exp_t r;
        int n;
        r.ep = 0; r.err = 0; r.conv = 0; r.tmo = 0;
        for (int e = 1; e <= MAX_EP; e++) begin
            n = count_wrong(e);
            r.ep = e;
            r.err = n;
            if (n == 0) begin
                r.conv = 1;
                break;
            end
        end
        return r;
    endfunction

    function automatic void clear_wrong();
        for (int e = 0; e <= MAX_EP; e++)
            for (int s = 0; s < NS; s++) wrong_tab[e][s] = 0;
    endfunction

    // Neuron model: accepts after an optional stall, answers after 0..3 cycles.
    initial begin
        bit pending, offer;
        bit pend_res;
        int lat_left, stall_left, s, e;
        bit [NI-1:0] offer_data;
        pending = 0; offer = 0; pend_res = 0; lat_left = 0; stall_left = 0;
        offer_data = '0;
        forever begin
            @(negedge clk);
            nrn_result_vld = 1'b0;
            nrn_in_rdy = 1'b0;
            if (!rst_n) begin
                pending = 0;
                offer = 0;
                continue;
            end
            if (pending) begin
                if (lat_left == 0) begin
                    pending = 0;
                    if (respond_en) begin
                        nrn_result_vld = 1'b1;
                        nrn_result_data = pend_res;
                    end
                end else begin
                    lat_left--;
                end
            end else if (o_nrn_in_vld) begin
                if (!offer) begin
                    offer = 1;
                    offer_data = o_nrn_in_data;
                    stall_left = (stall_cfg < 0) ? int'($urandom_range(0, 2)) : stall_cfg;
                end else begin
                    check("in_data stable while stalled", int'(o_nrn_in_data), int'(offer_data));
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    nrn_in_rdy = 1'b1;
                    offer = 0;
                    hs_cyc = cyc + 1;
                    if (train_active) begin
                        s = learn_k % NS;
                        e = learn_k / NS + 1;
                        check("nrn_mode learning", int'(o_nrn_mode), 1);
                        check("sample data", int'(o_nrn_in_data), int'(tb_data[s]));
                        check("sample expected", int'(o_nrn_expected), int'(tb_exp[s]));
                        pend_res = tb_exp[s] ^ ((e <= MAX_EP) ? wrong_tab[e][s] : 1'b0);
                        learn_k++;
                    end else begin
                        check("nrn_mode working", int'(o_nrn_mode), 0);
                        pend_res = ^o_nrn_in_data;
                    end
                    pending = 1;
                    lat_left = int'($urandom_range(0, 3));
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin
        train_exp_t t;
        bit r;
        forever begin
            @(negedge clk);
            if (rst_n && o_done) begin
                done_cnt++;
                done_cyc = cyc;
                train_active = 0;
                if (q_train.size() == 0) begin
                    check("unexpected done pulse", 1, 0);
                end else begin
                    t = q_train.pop_front();
                    check("epoch_cnt at done", int'(o_epoch_cnt), t.ep);
                    check("err_cnt at done", int'(o_err_cnt), t.err);
                    check("converged at done", int'(o_converged), int'(t.conv));
                    check("timeout at done", int'(o_timeout), int'(t.tmo));
                    check("busy at done", int'(o_busy), 0);
                end
            end
            if (rst_n && o_inf_res_vld) begin
                if (q_inf.size() == 0) begin
                    check("unexpected inference result", 1, 0);
                end else begin
                    r = q_inf.pop_front();
                    check("inference result", int'(o_inf_res_data), int'(r));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wr_sample(input int a, input bit [NI-1:0] d, input bit x);
        i_smp_wr_en = 1'b1;
        i_smp_wr_addr = 3'(a);
        i_smp_wr_data = d;
        i_smp_wr_exp = x;
        @(negedge clk);
        i_smp_wr_en = 1'b0;
        tb_data[a] = d;
        tb_exp[a] = x;
    endtask

    // Wait for idle; optionally throw ignored start/write traffic while busy.
    task automatic wait_idle(input int budget, input bit noise);
        int prev_ep;
        bit ok;
        ok = 0;
        prev_ep = int'(o_epoch_cnt);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!o_busy) begin
                i_start = 1'b0;
                i_smp_wr_en = 1'b0;
                ok = 1;
                break;
            end
            if (int'(o_epoch_cnt) != prev_ep) begin
                prev_ep = int'(o_epoch_cnt);
                check("mid-run err_cnt", int'(o_err_cnt), count_wrong(prev_ep));
            end
            if (noise) begin
                i_start = ($urandom_range(0, 3) == 0);
                i_smp_wr_en = 1'($urandom_range(0, 1));
                i_smp_wr_addr = 3'($urandom_range(0, 7));
                i_smp_wr_data = NI'($urandom_range(0, 7));
                i_smp_wr_exp = 1'($urandom_range(0, 1));
            end
        end
        if (!ok) begin
            check("busy wait expired", 1, 0);
            i_start = 1'b0;
            i_smp_wr_en = 1'b0;
        end
    endtask

    // kind: 0 = reference outcome, 1 = watchdog abort, 2 = no outcome expected
    task automatic begin_train(input int kind);
        train_exp_t t;
        if (kind == 0) begin
            q_train.push_back(ref_train());
        end else if (kind == 1) begin
            t.ep = 0; t.err = 0; t.conv = 0; t.tmo = 1;
            q_train.push_back(t);
        end
        learn_k = 0;
        train_active = 1;
        i_start = 1'b1;
    endtask

    task automatic run_train(input int kind);
        begin_train(kind);
        @(negedge clk);
        i_start = 1'b0;
        check("nrn_in_vld 1 cycle after start", int'(o_nrn_in_vld), 1);
        check("busy after start", int'(o_busy), 1);
        check("nrn_mode after start", int'(o_nrn_mode), 1);
        wait_idle(3000, kind == 0);
    endtask

    task automatic inf_wait_accept();
        bit ok;
        ok = 0;
        for (int n = 0; n < 3000; n++) begin
            #1;
            if (o_inf_rdy) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("inference request not accepted", 1, 0);
        @(negedge clk);
        i_inf_vld = 1'b0;
    endtask

    task automatic inf_req(input bit [NI-1:0] d, input bit exp_res);
        q_inf.push_back(exp_res);
        i_inf_vld = 1'b1;
        i_inf_data = d;
        inf_wait_accept();
        wait_idle(300, 0);
    endtask

    initial begin
        bit [NI-1:0] d;
        int d0, conv_ep;

        repeat (3) @(negedge clk);
        check("reset busy", int'(o_busy), 0);
        check("reset done", int'(o_done), 0);
        check("reset converged", int'(o_converged), 0);
        check("reset timeout", int'(o_timeout), 0);
        check("reset epoch_cnt", int'(o_epoch_cnt), 0);
        check("reset err_cnt", int'(o_err_cnt), 0);
        check("reset nrn_in_vld", int'(o_nrn_in_vld), 0);
        check("reset inf_rdy", int'(o_inf_rdy), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("inf_rdy when idle", int'(o_inf_rdy), 1);

        // AND truth table, model always right
        for (int a = 0; a < NS; a++) wr_sample(a, NI'(a), a == 7);
        clear_wrong();
        run_train(0);

        // sample 5 wrong in epochs 1..3
        clear_wrong();
        for (int e = 1; e <= 3; e++) wrong_tab[e][5] = 1;
        run_train(0);

        // sample 0 always wrong: epoch limit
        clear_wrong();
        for (int e = 1; e <= MAX_EP; e++) wrong_tab[e][0] = 1;
        run_train(0);

        // long ready stall on every transfer
        clear_wrong();
        stall_cfg = 5;
        run_train(0);
        stall_cfg = -1;

        // start and inference request in the same idle cycle
        clear_wrong();
        d = NI'($urandom_range(0, 7));
        begin_train(0);
        q_inf.push_back(^d);
        i_inf_vld = 1'b1;
        i_inf_data = d;
        #1;
        check("inf_rdy low with start", int'(o_inf_rdy), 0);
        @(negedge clk);
        i_start = 1'b0;
        check("training wins over inference", int'(o_nrn_mode), 1);
        d0 = done_cnt;
        inf_wait_accept();
        check("inference served after done", done_cnt - d0, 1);
        wait_idle(300, 0);

        // randomized sets, misprediction patterns and inference traffic
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < NS; a++)
                wr_sample(a, NI'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            clear_wrong();
            conv_ep = int'($urandom_range(1, MAX_EP + 1));
            for (int e = 1; e < conv_ep && e <= MAX_EP; e++)
                for (int s = 0; s < NS; s++) wrong_tab[e][s] = ($urandom_range(0, 3) == 0);
            run_train(0);
            for (int k = 0; k < 2; k++) begin
                d = NI'($urandom_range(0, 7));
                inf_req(d, ^d);
            end
        end

        // reset while waiting for a result: abort, no done pulse
        respond_en = 0;
        clear_wrong();
        begin_train(2);
        @(negedge clk);
        i_start = 1'b0;
        for (int n = 0; n < 50 && o_nrn_in_vld; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("abort busy", int'(o_busy), 0);
        check("abort done", int'(o_done), 0);
        check("abort epoch_cnt", int'(o_epoch_cnt), 0);
        check("abort nrn_in_vld", int'(o_nrn_in_vld), 0);
        check("abort nrn_mode", int'(o_nrn_mode), 0);
        check("abort nrn_in_data", int'(o_nrn_in_data), 0);
        check("abort nrn_expected", int'(o_nrn_expected), 0);
        check("abort inf_res_vld", int'(o_inf_res_vld), 0);
        check("abort inf_rdy", int'(o_inf_rdy), 0);
        train_active = 0;
        for (int a = 0; a < NS; a++) begin
            tb_data[a] = '0;
            tb_exp[a] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("no done after reset abort", done_cnt - d0, 0);
        respond_en = 1;
        // memory must come back cleared
        run_train(0);

`ifdef NEURON_TRAIN_CTRL_TIMEOUT_EN
        respond_en = 0;
        run_train(1);
        check("done cycles after WAIT_RES entry", done_cyc - hs_cyc, TMO);
        inf_req(NI'($urandom_range(0, 7)), 1'b0);
        check("timeout after inference abort", int'(o_timeout), 1);
        respond_en = 1;
        clear_wrong();
        run_train(0);
`endif

        repeat (3) @(negedge clk);
        check("training scoreboard drained", q_train.size(), 0);
        check("inference scoreboard drained", q_inf.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
